// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, default timing constants and width helper
// for the PLL bring-up sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } state_e;

    localparam int DEF_RST_PULSE_CYC    = 24;
    localparam int DEF_LOCK_STABLE_CYC  = 2400;
    localparam int DEF_LOCK_TIMEOUT_CYC = 240000;
    localparam int DEF_MAX_RETRIES      = 3;
    localparam int DEF_N_DOM            = 4;
    localparam int DEF_DOM_GAP_CYC      = 16;

    // Bits needed to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] r_ff;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ff <= 2'b00;
        else        r_ff <= {r_ff[0], d};

    assign q = r_ff[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses the PLL reset, qualifies lock with bounded retries,
// then releases downstream domain resets in order; all outputs registered.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int N_DOM            = DEF_N_DOM,
    parameter int DOM_GAP_CYC      = DEF_DOM_GAP_CYC
) (
    input  logic                                refclk,
    input  logic                                rst_n,
    input  logic                                pll_locked,
    input  logic                                soft_reset_req,
    output logic                                pll_rst,
    output logic [N_DOM-1:0]                    dom_rst_n,
    output logic                                all_ready,
    output logic                                fault,
    output logic [cnt_w(MAX_RETRIES+1)-1:0]     retry_cnt
);

    localparam int CW = cnt_w(LOCK_TIMEOUT_CYC + 1);
    localparam int RW = cnt_w(MAX_RETRIES + 1);

    localparam logic [CW-1:0]    C_PULSE   = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0]    C_STABLE  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0]    C_TIMEOUT = CW'(LOCK_TIMEOUT_CYC);
    localparam logic [CW-1:0]    C_GAP     = CW'(DOM_GAP_CYC - 1);
    localparam logic [RW-1:0]    C_MAX     = RW'(MAX_RETRIES);
    localparam logic [N_DOM-1:0] DOM_LSB   = N_DOM'(1);

    logic             w_lock_s;
    state_e           r_state, w_nxt;
    logic [CW-1:0]    r_cnt;
    logic [N_DOM-1:0] r_dom, w_dom_nxt;
    logic [RW-1:0]    r_retry, w_retry_nxt;
    logic             r_pll_rst, r_fault, r_all_ready;
    logic             w_step;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_lock_s)
    );

    always_comb begin
        w_nxt       = r_state;
        w_retry_nxt = r_retry;
        w_step      = 1'b0;
        case (r_state)
            RESET_PLL: if (r_cnt == C_PULSE) w_nxt = WAIT_LOCK;
            WAIT_LOCK:
                if (w_lock_s) w_nxt = STABLE;
                else if (r_cnt == C_TIMEOUT) begin
                    if (r_retry == C_MAX) w_nxt = FAULT;
                    else begin
                        w_nxt       = RESET_PLL;
                        w_retry_nxt = r_retry + 1'b1;
                    end
                end
            STABLE:
                if (!w_lock_s) w_nxt = WAIT_LOCK;
                else if (r_cnt == C_STABLE) w_nxt = RELEASE;
            RELEASE:
                if (!w_lock_s) w_nxt = RESET_PLL;
                else if (r_dom[N_DOM-1]) w_nxt = RUN;
                else w_step = (r_cnt == C_GAP);
            RUN: if (!w_lock_s) w_nxt = RESET_PLL;
            default: w_nxt = r_state;
        endcase
        if (w_nxt == RUN) w_retry_nxt = '0;
        // A restart request overrides whatever the state logic decided above.
        if (soft_reset_req) begin
            w_nxt       = RESET_PLL;
            w_retry_nxt = '0;
            w_step      = 1'b0;
        end
        w_dom_nxt = (w_nxt == RUN) ? r_dom :
                    (w_nxt != RELEASE) ? '0 :
                    (r_state != RELEASE) ? DOM_LSB :
                    w_step ? ((r_dom << 1) | DOM_LSB) : r_dom;
    end

    always_ff @(posedge refclk or negedge rst_n)
        if (!rst_n) begin
            r_state     <= RESET_PLL;
            r_cnt       <= '0;
            r_dom       <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_fault     <= 1'b0;
            r_all_ready <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_cnt       <= (w_nxt != r_state || soft_reset_req || w_step) ? '0 : r_cnt + 1'b1;
            r_dom       <= w_dom_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= (w_nxt == RESET_PLL) || (w_nxt == FAULT);
            r_fault     <= (w_nxt == FAULT);
            r_all_ready <= (w_nxt == RUN);
        end

    assign pll_rst   = r_pll_rst;
    assign dom_rst_n = r_dom;
    assign all_ready = r_all_ready;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;

endmodule
